// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND BCD counter path.
// to_bcd builds elaboration-time BCD constants; bcd_valid checks nibble range.
package fnd_pkg;

  localparam int BCD_W = 4;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[i*BCD_W +: BCD_W] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Narrower vectors are zero-extended by the caller; zero nibbles pass.
  function automatic logic bcd_valid(input logic [31:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (v[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of the counter chain, wrapping 0..9.
// Ports: i_step (change this digit), i_up, i_clear, i_load/i_load_nib, o_digit, o_carry.
module bcd_digit_cell
  import fnd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_nib,
  input  logic             i_step,
  input  logic             i_up,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_carry
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    o_carry = i_step &&
      (i_up ? (digit_q == 4'd9) : (digit_q == 4'd0));
    if (i_clear) begin
      digit_d = '0;
    end else if (i_load) begin
      digit_d = i_load_nib;
    end else if (i_step) begin
      if (i_up) begin
        digit_d = (digit_q == 4'd9) ? 4'd0
                : digit_q + BCD_W'(1);
      end else begin
        digit_d = (digit_q == 4'd0) ? 4'd9
                : digit_q - BCD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) digit_q <= '0;
    else         digit_q <= digit_d;
  end

  assign o_digit = digit_q;

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD up/down counter with prescaler, modulo, load and clear.
// Ports: i_clk, i_reset, i_en, i_up, i_clear, i_load, i_load_val -> o_bcd, o_step, o_wrap, o_load_err.
module bcd_mod_counter
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000,
  parameter int MAX_VAL    = 9999
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_en,
  input  logic                        i_up,
  input  logic                        i_clear,
  input  logic                        i_load,
  input  logic [BCD_W*NUM_DIGITS-1:0] i_load_val,
  output logic [BCD_W*NUM_DIGITS-1:0] o_bcd,
  output logic                        o_step,
  output logic                        o_wrap,
  output logic                        o_load_err
);

  localparam int W  = BCD_W * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  MAX_BCD  = W'(to_bcd(MAX_VAL));

  logic [PW-1:0]         pre_q;
  logic [PW-1:0]         pre_d;
  logic                  step_q;
  logic                  step_d;
  logic                  wrap_q;
  logic                  wrap_d;
  logic                  err_q;
  logic                  err_d;

  logic [W-1:0]          bcd;
  logic                  tick;
  logic                  at_term;
  logic                  load_ok;
  logic                  load_acc;
  logic                  force_ld;
  logic [W-1:0]          force_val;
  logic [NUM_DIGITS-1:0] dig_step;
  logic [NUM_DIGITS-1:0] carry;
  logic                  unused_carry;

  // BCD ordering matches numeric ordering once nibbles are valid.
  assign load_ok = bcd_valid(32'(i_load_val))
                && (i_load_val <= MAX_BCD);

  always_comb begin
    tick     = i_en && (pre_q == PRE_LAST);
    at_term  = i_up ? (bcd == MAX_BCD) : (bcd == '0);
    step_d   = tick && !i_clear && !i_load;
    wrap_d   = step_d && at_term;
    load_acc = !i_clear && i_load && load_ok;
    err_d    = !i_clear && i_load && !load_ok;
    // A wrap reuses the load path so the chain is bypassed.
    force_ld  = load_acc || wrap_d;
    force_val = i_load_val;
    if (wrap_d) force_val = i_up ? '0 : MAX_BCD;
    pre_d = pre_q;
    if (i_clear || load_acc) begin
      pre_d = '0;
    end else if (i_load) begin
      pre_d = pre_q;
    end else if (i_en) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  assign dig_step[0] = step_d && !at_term;

  for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_chain
    assign dig_step[g] = carry[g-1];
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_cell u_cell (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (i_clear),
      .i_load     (force_ld),
      .i_load_nib (force_val[g*BCD_W +: BCD_W]),
      .i_step     (dig_step[g]),
      .i_up       (i_up),
      .o_digit    (bcd[g*BCD_W +: BCD_W]),
      .o_carry    (carry[g])
    );
  end

  // The top digit never carries out: that case is a wrap.
  assign unused_carry = carry[NUM_DIGITS-1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign o_bcd      = bcd;
  assign o_step     = step_q;
  assign o_wrap     = wrap_q;
  assign o_load_err = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench: three counter configurations against an integer model.
// Directed scenarios followed by a randomized phase.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  logic i_reset, i_en, i_up, i_clear, i_load;
  logic [15:0] i_load_val;
  logic [2:0][15:0] bcd;
  logic [2:0] stp, wrp, err;

  int checks = 0;
  int failures = 0;

  int maxv[3] = '{9999, 59, 9999};
  int tdiv[3] = '{3, 3, 1};
  int mval[3];
  int mpre[3];
  bit mstep[3], mwrap[3], merr[3];

  always #5 clk = ~clk;

  bcd_mod_counter #(.NUM_DIGITS(4), .TICK_DIV(3), .MAX_VAL(9999)) u0 (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en), .i_up(i_up),
    .i_clear(i_clear), .i_load(i_load), .i_load_val(i_load_val),
    .o_bcd(bcd[0]), .o_step(stp[0]), .o_wrap(wrp[0]),
    .o_load_err(err[0]));

  bcd_mod_counter #(.NUM_DIGITS(4), .TICK_DIV(3), .MAX_VAL(59)) u1 (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en), .i_up(i_up),
    .i_clear(i_clear), .i_load(i_load), .i_load_val(i_load_val),
    .o_bcd(bcd[1]), .o_step(stp[1]), .o_wrap(wrp[1]),
    .o_load_err(err[1]));

  bcd_mod_counter #(.NUM_DIGITS(4), .TICK_DIV(1), .MAX_VAL(9999)) u2 (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en), .i_up(i_up),
    .i_clear(i_clear), .i_load(i_load), .i_load_val(i_load_val),
    .o_bcd(bcd[2]), .o_step(stp[2]), .o_wrap(wrp[2]),
    .o_load_err(err[2]));

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal value of a packed BCD word, or -1 if any nibble is not a digit.
  function automatic int bcd2int(input logic [15:0] b);
    int v;
    int n;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      n = int'(b[i*4 +: 4]);
      if (n > 9) return -1;
      v = v * 10 + n;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int lv;
    for (int k = 0; k < 3; k++) begin
      mstep[k] = 0;
      mwrap[k] = 0;
      merr[k]  = 0;
      if (i_reset || i_clear) begin
        mval[k] = 0;
        mpre[k] = 0;
      end else if (i_load) begin
        lv = bcd2int(i_load_val);
        if (lv >= 0 && lv <= maxv[k]) begin
          mval[k] = lv;
          mpre[k] = 0;
        end else begin
          merr[k] = 1;
        end
      end else if (i_en) begin
        if (mpre[k] == tdiv[k] - 1) begin
          mpre[k] = 0;
          mstep[k] = 1;
          if (i_up) begin
            if (mval[k] == maxv[k]) begin
              mval[k] = 0;
              mwrap[k] = 1;
            end else mval[k] = mval[k] + 1;
          end else begin
            if (mval[k] == 0) begin
              mval[k] = maxv[k];
              mwrap[k] = 1;
            end else mval[k] = mval[k] - 1;
          end
        end else begin
          mpre[k] = mpre[k] + 1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.bcd", k), 32'(bcd[k]), 32'(int2bcd(mval[k])));
      chk($sformatf("u%0d.step", k), 32'(stp[k]), 32'(mstep[k]));
      chk($sformatf("u%0d.wrap", k), 32'(wrp[k]), 32'(mwrap[k]));
      chk($sformatf("u%0d.err", k), 32'(err[k]), 32'(merr[k]));
    end
  endtask

  task automatic wait_step(input int k, input int budget);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!stp[k] && n < budget);
    chk($sformatf("u%0d.wait_step", k), 32'(stp[k]), 32'd1);
  endtask

  task automatic load(input logic [15:0] v);
    i_load = 1'b1;
    i_load_val = v;
    cyc();
    i_load = 1'b0;
  endtask

  initial begin
    int nstep;
    int r;
    i_reset = 1'b1; i_en = 1'b0; i_up = 1'b1;
    i_clear = 1'b0; i_load = 1'b0; i_load_val = '0;
    for (int k = 0; k < 3; k++) begin
      mval[k] = 0; mpre[k] = 0;
    end
    cyc();
    cyc();
    chk("reset.bcd", 32'(bcd[0]), 32'h0);
    chk("reset.pulses", 32'({stp[0], wrp[0], err[0]}), 32'h0);
    i_reset = 1'b0;

    // 1: free counting up, step every third cycle
    i_en = 1'b1;
    nstep = 0;
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (stp[0]) nstep++;
    end
    chk("count30.steps", 32'(nstep), 32'd10);
    chk("count30.bcd", 32'(bcd[0]), 32'h0010);

    // 2: wrap up from 9999, then down from 0
    load(16'h9999);
    wait_step(0, 5);
    chk("wrap_up.bcd", 32'(bcd[0]), 32'h0000);
    chk("wrap_up.wrap", 32'(wrp[0]), 32'd1);
    i_up = 1'b0;
    wait_step(0, 5);
    chk("wrap_dn.bcd", 32'(bcd[0]), 32'h9999);
    chk("wrap_dn.wrap", 32'(wrp[0]), 32'd1);

    // 3: modulo 59 on u1
    i_up = 1'b1;
    load(16'h0059);
    wait_step(1, 5);
    chk("mod59_up.bcd", 32'(bcd[1]), 32'h0000);
    chk("mod59_up.wrap", 32'(wrp[1]), 32'd1);
    i_up = 1'b0;
    wait_step(1, 5);
    chk("mod59_dn.bcd", 32'(bcd[1]), 32'h0059);
    load(16'h0060);
    chk("mod59_ld.err", 32'(err[1]), 32'd1);
    chk("mod59_ld.bcd", 32'(bcd[1]), 32'h0059);

    // 4: invalid nibble, then borrow chain
    load(16'h00A3);
    chk("badnib.err", 32'(err[0]), 32'd1);
    chk("badnib.bcd", 32'(bcd[0]), 32'h0060);
    load(16'h1000);
    wait_step(0, 5);
    chk("borrow.bcd", 32'(bcd[0]), 32'h0999);

    // 5: enable gap delays the step by one cycle; clear kills a step
    i_up = 1'b1;
    load(16'h0000);
    cyc();
    chk("gap.c1", 32'(stp[0]), 32'd0);
    i_en = 1'b0;
    cyc();
    chk("gap.c2", 32'(stp[0]), 32'd0);
    i_en = 1'b1;
    cyc();
    chk("gap.c3", 32'(stp[0]), 32'd0);
    cyc();
    chk("gap.c4", 32'(stp[0]), 32'd1);
    chk("gap.bcd", 32'(bcd[0]), 32'h0001);
    cyc();
    cyc();
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    chk("clr.bcd", 32'(bcd[0]), 32'h0000);
    chk("clr.step", 32'(stp[0]), 32'd0);

    // 6: reset mid-count, prescaler restarts
    load(16'h0041);
    wait_step(0, 5);
    chk("rst.pre_bcd", 32'(bcd[0]), 32'h0042);
    cyc();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    chk("rst.bcd", 32'(bcd[0]), 32'h0000);
    chk("rst.pulses", 32'({stp[0], wrp[0], err[0]}), 32'h0);
    cyc();
    chk("rst.c1", 32'(stp[0]), 32'd0);
    cyc();
    chk("rst.c2", 32'(stp[0]), 32'd0);
    cyc();
    chk("rst.c3", 32'(stp[0]), 32'd1);

    // TICK_DIV=1: step on every enabled cycle
    nstep = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (stp[2]) nstep++;
    end
    chk("div1.steps", 32'(nstep), 32'd5);

    // randomized phase
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(0, 99));
      i_reset = (r == 0);
      i_clear = (r >= 1 && r <= 3);
      i_load  = (r >= 4 && r <= 10);
      i_en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) i_up = ~i_up;
      case ($urandom_range(0, 3))
        0, 1: i_load_val = int2bcd(int'($urandom_range(0, 9999)));
        2:    i_load_val = int2bcd(int'($urandom_range(0, 70)));
        default: i_load_val = 16'($urandom);
      endcase
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
